// File: rtl/mcu_fb_writer.sv
// mcu_fb_writer: places JPEG-decoder MCU pixels into a small RGB444 frame buffer.
//
// A pixel handshake (px_we & px_next) feeds a one-deep address/colour stage.
// Pixels inside the visible window (image size clipped to the frame buffer)
// are pushed into a small write FIFO. The FIFO drains to the frame buffer
// whenever fb_ready is high. Once the last pixel of the last MCU has been
// accepted, the block drains the pipeline and then holds frame_done until rst.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   cfg_*                    image configuration, latched in IDLE when cfg_en=1
//   px_we, px_begin, px_end  decoder pixel strobe and MCU framing
//   px_r/g/b, px_adr         pixel colour and index inside the MCU
//   px_x_mcu, px_y_mcu       MCU coordinates
//   px_next                  ready back to the decoder
//   fb_ready                 frame buffer write port available
//   fb_wr_en/addr/data       frame buffer write port (RGB444)
//   frame_done               whole frame written
//   wr_count                 saturating count of writes this frame
module mcu_fb_writer #(
  parameter int unsigned FB_WIDTH      = 32,
  parameter int unsigned FB_HEIGHT     = 32,
  parameter int unsigned FB_ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_en,
  input  logic                     cfg_411,
  input  logic [15:0]              cfg_width,
  input  logic [15:0]              cfg_height,
  input  logic [12:0]              cfg_mcu_w,
  input  logic [12:0]              cfg_mcu_h,
  input  logic                     px_we,
  input  logic                     px_begin,
  input  logic                     px_end,
  input  logic [7:0]               px_r,
  input  logic [7:0]               px_g,
  input  logic [7:0]               px_b,
  input  logic [7:0]               px_adr,
  input  logic [12:0]              px_x_mcu,
  input  logic [12:0]              px_y_mcu,
  output logic                     px_next,
  input  logic                     fb_ready,
  output logic                     fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [11:0]              fb_wr_data,
  output logic                     frame_done,
  output logic [15:0]              wr_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthCmp = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StActive, StDrain, StDone} state_e;

  state_e      state_q;
  logic        frame_done_q;
  logic        cfg411_q;
  logic [15:0] width_q;
  logic [15:0] height_q;
  logic [12:0] mcu_w_q;
  logic [12:0] mcu_h_q;

  // Stage 1: registered address/colour of the pixel accepted last cycle.
  logic                     s1_valid_q;
  logic                     s1_keep_q;
  logic [FB_ADDR_WIDTH-1:0] s1_addr_q;
  logic [11:0]              s1_data_q;

  // Write FIFO.
  logic [FB_ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [11:0]              fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]          rd_ptr_q;
  logic [PtrW-1:0]          wr_ptr_q;
  logic [CntW-1:0]          count_q;
  logic [15:0]              wr_count_q;

  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     accept;
  logic                     last_px;
  logic [CntW:0]            occ;
  logic [3:0]               col;
  logic [3:0]               row;
  logic [16:0]              x;
  logic [16:0]              y;
  logic [15:0]              width_lim;
  logic [15:0]              height_lim;
  logic                     keep;
  logic [FB_ADDR_WIDTH-1:0] addr_calc;
  logic [11:0]              data_calc;

  // px_begin and the low colour nibbles carry no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{px_begin, px_r[3:0], px_g[3:0], px_b[3:0]};

  // Handshake. The stage-1 slot counts against FIFO space so it can always push.
  assign fifo_empty = (count_q == '0);
  assign occ        = {1'b0, count_q} + {{CntW{1'b0}}, s1_valid_q};
  assign px_next    = (state_q == StActive) && (occ < DepthCmp);
  assign accept     = px_we && px_next;
  assign last_px    = accept && px_end && (px_x_mcu == mcu_w_q - 13'd1) &&
                      (px_y_mcu == mcu_h_q - 13'd1);

  // Pixel geometry, kept 17 bits wide so nothing wraps before the clip compare.
  always_comb begin
    col = cfg411_q ? px_adr[3:0] : {1'b0, px_adr[2:0]};
    row = cfg411_q ? px_adr[7:4] : {1'b0, px_adr[5:3]};
    x   = (cfg411_q ? {px_x_mcu, 4'b0000} : {1'b0, px_x_mcu, 3'b000}) + {13'd0, col};
    y   = (cfg411_q ? {px_y_mcu, 4'b0000} : {1'b0, px_y_mcu, 3'b000}) + {13'd0, row};
    width_lim  = (width_q < 16'(FB_WIDTH)) ? width_q : 16'(FB_WIDTH);
    height_lim = (height_q < 16'(FB_HEIGHT)) ? height_q : 16'(FB_HEIGHT);
    keep       = (x < {1'b0, width_lim}) && (y < {1'b0, height_lim});
    addr_calc  = FB_ADDR_WIDTH'(32'(y) * 32'(FB_WIDTH) + 32'(x));
    data_calc  = {px_r[7:4], px_g[7:4], px_b[7:4]};
  end

  assign push = s1_valid_q && s1_keep_q;
  assign pop  = fb_wr_en;

  assign fb_wr_en   = !fifo_empty && fb_ready && (state_q != StIdle);
  assign fb_wr_addr = fb_wr_en ? fifo_addr_q[rd_ptr_q] : '0;
  assign fb_wr_data = fb_wr_en ? fifo_data_q[rd_ptr_q] : '0;
  assign frame_done = frame_done_q;
  assign wr_count   = wr_count_q;

  // Control FSM with configuration latch and registered frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      frame_done_q <= 1'b0;
      cfg411_q     <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      mcu_w_q      <= '0;
      mcu_h_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_en) begin
            cfg411_q <= cfg_411;
            width_q  <= cfg_width;
            height_q <= cfg_height;
            mcu_w_q  <= cfg_mcu_w;
            mcu_h_q  <= cfg_mcu_h;
            state_q  <= StActive;
          end
        end
        StActive: begin
          if (last_px) state_q <= StDrain;
        end
        StDrain: begin
          if (!s1_valid_q && fifo_empty) begin
            state_q      <= StDone;
            frame_done_q <= 1'b1;
          end
        end
        StDone: state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_keep_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_keep_q <= keep;
        s1_addr_q <= addr_calc;
        s1_data_q <= data_calc;
      end
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= s1_addr_q;
      fifo_data_q[wr_ptr_q] <= s1_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pop && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_mcu_fb_writer.sv
// Directed self-checking bench for mcu_fb_writer (default parameters:
// 32x32 frame buffer, 10-bit address, 4-entry FIFO).
module tb_mcu_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en, cfg_411;
  logic [15:0] cfg_width, cfg_height;
  logic [12:0] cfg_mcu_w, cfg_mcu_h;
  logic        px_we, px_begin, px_end;
  logic [7:0]  px_r, px_g, px_b, px_adr;
  logic [12:0] px_x_mcu, px_y_mcu;
  logic        px_next;
  logic        fb_ready;
  logic        fb_wr_en;
  logic [9:0]  fb_wr_addr;
  logic [11:0] fb_wr_data;
  logic        frame_done;
  logic [15:0] wr_count;

  mcu_fb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_411    (cfg_411),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_mcu_w  (cfg_mcu_w),
    .cfg_mcu_h  (cfg_mcu_h),
    .px_we      (px_we),
    .px_begin   (px_begin),
    .px_end     (px_end),
    .px_r       (px_r),
    .px_g       (px_g),
    .px_b       (px_b),
    .px_adr     (px_adr),
    .px_x_mcu   (px_x_mcu),
    .px_y_mcu   (px_y_mcu),
    .px_next    (px_next),
    .fb_ready   (fb_ready),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .frame_done (frame_done),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes, in order, with the cycle they happened on.
  logic [9:0]  w_addr [$];
  logic [11:0] w_data [$];
  int          w_cyc  [$];
  always @(negedge clk) begin
    if (fb_wr_en) begin
      w_addr.push_back(fb_wr_addr);
      w_data.push_back(fb_wr_data);
      w_cyc.push_back(cyc);
    end
  end

  // Expected writes from the bench's own geometry model.
  logic [9:0]  e_addr [$];
  logic [11:0] e_data [$];

  // Current frame configuration as the bench sees it.
  bit cur_411;
  int cur_w, cur_h, cur_mw, cur_mh;
  int last_acc_cyc;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [23:0] colour(input int mx, input int adr);
    if (mx == 0 && adr == 0) return 24'hF35A0C;
    return {8'(adr), 8'(255 - adr), 8'(mx * 40 + 7)};
  endfunction

  task automatic decode(input int idx, output int mx, output int my, output int adr,
                        output bit last);
    int s, per, m;
    s    = cur_411 ? 16 : 8;
    per  = s * s;
    m    = idx / per;
    adr  = idx % per;
    mx   = m % cur_mw;
    my   = m / cur_mw;
    last = (adr == per - 1) && (mx == cur_mw - 1) && (my == cur_mh - 1);
  endtask

  task automatic drive_idx(input int idx);
    int mx, my, adr;
    bit last;
    logic [23:0] c;
    decode(idx, mx, my, adr, last);
    c        = colour(mx, adr);
    px_we    = 1'b1;
    px_begin = (adr == 0);
    px_end   = (adr == (cur_411 ? 255 : 63));
    px_adr   = 8'(adr);
    px_x_mcu = 13'(mx);
    px_y_mcu = 13'(my);
    px_r     = c[23:16];
    px_g     = c[15:8];
    px_b     = c[7:0];
  endtask

  task automatic note_accept(input int idx);
    int mx, my, adr, s, x, y, wl, hl;
    bit last;
    logic [23:0] c;
    decode(idx, mx, my, adr, last);
    s  = cur_411 ? 16 : 8;
    x  = mx * s + (adr % s);
    y  = my * s + (adr / s);
    wl = (cur_w < 32) ? cur_w : 32;
    hl = (cur_h < 32) ? cur_h : 32;
    c  = colour(mx, adr);
    if (x < wl && y < hl) begin
      e_addr.push_back(10'(y * 32 + x));
      e_data.push_back({c[23:20], c[15:12], c[7:4]});
    end
  endtask

  // Present pixel idx and hold it until accepted (bounded).
  task automatic send_idx(input int idx);
    bit ok = 1'b0;
    drive_idx(idx);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (px_next) begin
        ok = 1'b1;
        last_acc_cyc = cyc;
        note_accept(idx);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout: pixel %0d observed not accepted expected accepted", idx);
    end
  endtask

  task automatic configure(input bit m411, input int w, input int h, input int mw,
                           input int mh);
    cur_411 = m411; cur_w = w; cur_h = h; cur_mw = mw; cur_mh = mh;
    cfg_en = 1'b1; cfg_411 = m411;
    cfg_width = 16'(w); cfg_height = 16'(h);
    cfg_mcu_w = 13'(mw); cfg_mcu_h = 13'(mh);
    @(posedge clk); #1;
    // Scramble the inputs: the latched copy must be the one in use.
    cfg_en = 1'b0; cfg_411 = ~m411;
    cfg_width = 16'd1; cfg_height = 16'd1;
    cfg_mcu_w = 13'd7; cfg_mcu_h = 13'd7;
  endtask

  task automatic wait_done(output bit seen, output int dcyc);
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_queues();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    e_addr.delete(); e_data.delete();
  endtask

  function automatic int order_errors();
    int bad = 0;
    int n = (w_addr.size() < e_addr.size()) ? w_addr.size() : e_addr.size();
    for (int k = 0; k < n; k++)
      if (w_addr[k] !== e_addr[k] || w_data[k] !== e_data[k]) bad++;
    return bad;
  endfunction

  function automatic logic [31:0] w_addr_at(input int k);
    return (k < w_addr.size()) ? 32'(w_addr[k]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] w_data_at(input int k);
    return (k < w_data.size()) ? 32'(w_data[k]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int dcyc, first_acc, acc, maxa, last_w;

    rst = 1'b1; cfg_en = 1'b0; cfg_411 = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_mcu_w = '0; cfg_mcu_h = '0;
    px_we = 1'b0; px_begin = 1'b0; px_end = 1'b0;
    px_r = '0; px_g = '0; px_b = '0; px_adr = '0; px_x_mcu = '0; px_y_mcu = '0;
    fb_ready = 1'b1;
    cur_411 = 1'b1; cur_w = 16; cur_h = 16; cur_mw = 1; cur_mh = 1;
    last_acc_cyc = 0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_px_next", px_next, 0);
    check("rst_fb_wr_en", fb_wr_en, 0);
    check("rst_fb_wr_addr", fb_wr_addr, 0);
    check("rst_fb_wr_data", fb_wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_count", wr_count, 0);
    rst = 1'b0;

    // px_we in IDLE is ignored.
    drive_idx(5);
    repeat (4) @(posedge clk);
    #1;
    px_we = 1'b0;
    check("idle_px_next", px_next, 0);
    check("idle_no_writes", w_addr.size(), 0);
    check("idle_wr_count", wr_count, 0);

    // Frame 1: single 16x16 MCU, no backpressure.
    clear_queues();
    configure(1'b1, 16, 16, 1, 1);
    check("active_px_next", px_next, 1);
    send_idx(0);
    first_acc = last_acc_cyc;
    for (int i = 1; i < 256; i++) send_idx(i);
    px_we = 1'b0;
    wait_done(seen, dcyc);
    last_w = (w_cyc.size() > 0) ? w_cyc[w_cyc.size() - 1] : -100;
    check("f1_done_seen", seen, 1);
    check("f1_done_timing", dcyc, last_w + 2);
    check("f1_latency", (w_cyc.size() > 0) ? w_cyc[0] : -1, first_acc + 2);
    check("f1_n_writes", w_addr.size(), 256);
    check("f1_wr_count", wr_count, 256);
    check("f1_addr_px17", w_addr_at(17), 33);
    check("f1_colour_px0", w_data_at(0), 12'hF50);
    check("f1_order", order_errors(), 0);

    // DONE holds and ignores further pixels.
    drive_idx(3);
    repeat (3) @(posedge clk);
    #1;
    px_we = 1'b0;
    check("done_hold", frame_done, 1);
    check("done_px_next", px_next, 0);
    check("done_wr_count", wr_count, 256);

    // Frame 2: 8x8 MCUs, 5x1, width 40 clipped to 32, starting under backpressure.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("f2_rst_done", frame_done, 0);
    check("f2_rst_wr_count", wr_count, 0);
    clear_queues();
    fb_ready = 1'b0;
    configure(1'b0, 40, 8, 5, 1);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive_idx(acc);
      @(negedge clk);
      if (px_next) begin
        note_accept(acc);
        acc++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", acc, 4);
    check("bp_px_next", px_next, 0);
    check("bp_no_writes", w_addr.size(), 0);
    fb_ready = 1'b1;
    for (int i = acc; i < 320; i++) send_idx(i);
    px_we = 1'b0;
    wait_done(seen, dcyc);
    maxa = 0;
    foreach (w_addr[k]) if (int'(w_addr[k]) > maxa) maxa = int'(w_addr[k]);
    check("f2_done_seen", seen, 1);
    check("f2_n_writes", w_addr.size(), 256);
    check("f2_wr_count", wr_count, 256);
    check("f2_addr_below_256", (maxa < 256), 1);
    check("f2_order", order_errors(), 0);

    // Frame 3: reset after 100 of 256 pixels, then a clean frame.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_queues();
    configure(1'b1, 16, 16, 1, 1);
    for (int i = 0; i < 100; i++) send_idx(i);
    px_we = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_fb_wr_en", fb_wr_en, 0);
    check("mid_rst_wr_count", wr_count, 0);
    check("mid_rst_px_next", px_next, 0);
    clear_queues();
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_idle_px_next", px_next, 0);
    check("mid_rst_no_writes", w_addr.size(), 0);
    configure(1'b1, 16, 16, 1, 1);
    for (int i = 0; i < 256; i++) send_idx(i);
    px_we = 1'b0;
    wait_done(seen, dcyc);
    check("f3_done_seen", seen, 1);
    check("f3_n_writes", w_addr.size(), 256);
    check("f3_wr_count", wr_count, 256);
    check("f3_order", order_errors(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
